// File: rtl/abr_params_pkg.sv
// Shared constants and types for the ML-KEM (eta=2) CBD polynomial sampler sequencer.
package abr_params_pkg;

    localparam int MLKEM_ETA     = 2;
    localparam int MLKEM_Q_WIDTH = 12;
    localparam int COEFF_PER_CLK = 4;
    localparam int CHUNK_W       = COEFF_PER_CLK * 2 * MLKEM_ETA;
    localparam int COEF_W        = COEFF_PER_CLK * MLKEM_Q_WIDTH;

    // 256 coefficients x 4 bits = 16 words of 64 bits, returned as 64 writes of 4 coefficients
    localparam int WORD_CNT_W = 5;
    localparam int WR_CNT_W   = 7;
    localparam logic [WORD_CNT_W-1:0] WORDS_PER_POLY  = 5'd16;
    localparam logic [WR_CNT_W-1:0]   WRITES_PER_POLY = 7'd64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } cbd_state_e;

endpackage

// File: rtl/cbd_chunk_buf.sv
// One-word staging buffer: slices sponge words into sampler chunks, LSB chunk first,
// and accepts the next word in the same cycle the last chunk leaves.
module cbd_chunk_buf
    import abr_params_pkg::*;
#(
    parameter int WORD_W = 64
) (
    input  logic               clk,
    input  logic               clr_i,
    input  logic               accept_en_i,
    input  logic               word_valid_i,
    input  logic [WORD_W-1:0]  word_i,
    input  logic               hold_i,
    output logic               word_rdy_o,
    output logic               chunk_valid_o,
    output logic [CHUNK_W-1:0] chunk_o,
    output logic               chunk_take_o
);

    localparam int NCHUNK = WORD_W / CHUNK_W;
    localparam int IDX_W  = $clog2(NCHUNK);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    logic [NCHUNK-1:0][CHUNK_W-1:0] word_q, word_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic                           full_q, full_d;
    logic                           last_take;
    logic                           load;

    assign chunk_take_o  = full_q & ~hold_i;
    assign last_take     = chunk_take_o & (idx_q == LAST_IDX);
    assign word_rdy_o    = accept_en_i & (~full_q | last_take);
    assign load          = word_valid_i & word_rdy_o;
    assign chunk_valid_o = full_q;
    assign chunk_o       = word_q[idx_q];

    // NOTE: every variable assigned here gets a default first, so no latch is inferred.
    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        full_d = full_q;
        if (load) begin
            word_d = word_i;
            idx_d  = '0;
            full_d = 1'b1;
        end else if (last_take) begin
            idx_d  = '0;
            full_d = 1'b0;
        end else if (chunk_take_o) begin
            idx_d  = idx_q + 1'b1;
        end
    end

    // NOTE: the data register is cleared as well, so chunk_o reads zero after reset/zeroize.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            word_q <= '0;
            idx_q  <= '0;
            full_q <= 1'b0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
            full_q <= full_d;
        end
    end

endmodule

// File: rtl/cbd_poly_sampler_seq.sv
// Sequences CBD (eta=2) sampling of ML-KEM noise polynomials: one sponge squeeze per
// polynomial, chunks to the sampler, returned coefficients written to consecutive addresses.
module cbd_poly_sampler_seq
    import abr_params_pkg::*;
#(
    parameter int WORD_W     = 64,
    parameter int MEM_ADDR_W = 15,
    parameter int NPOLY_W    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  zeroize,
    input  logic                  start_i,
    input  logic [MEM_ADDR_W-1:0] base_addr_i,
    input  logic [NPOLY_W-1:0]    num_poly_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  sq_req_o,
    input  logic                  sp_valid_i,
    input  logic [WORD_W-1:0]     sp_data_i,
    output logic                  sp_rdy_o,
    output logic                  samp_valid_o,
    output logic [CHUNK_W-1:0]    samp_data_o,
    input  logic                  samp_hold_i,
    input  logic                  coef_valid_i,
    input  logic [COEF_W-1:0]     coef_i,
    output logic                  mem_we_o,
    output logic [MEM_ADDR_W-1:0] mem_addr_o,
    output logic [COEF_W-1:0]     mem_wdata_o
);

    cbd_state_e              state_q, state_d;
    logic [WORD_CNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic [WR_CNT_W-1:0]     wr_cnt_q, wr_cnt_d;
    logic [WR_CNT_W-1:0]     pend_q, pend_d;
    logic [NPOLY_W-1:0]      poly_left_q, poly_left_d;
    logic [MEM_ADDR_W-1:0]   addr_q, addr_d;
    logic                    we_q;
    logic [MEM_ADDR_W-1:0]   wr_addr_q;
    logic [COEF_W-1:0]       wr_data_q;

    logic clr;
    logic run;
    logic poly_done;
    logic word_take;
    logic chunk_take;
    logic coef_take;

    assign clr       = rst | zeroize;
    assign poly_done = (wr_cnt_q == WRITES_PER_POLY);
    assign word_take = sp_valid_i & sp_rdy_o;

    cbd_chunk_buf #(
        .WORD_W (WORD_W)
    ) u_chunk_buf (
        .clk           (clk),
        .clr_i         (clr),
        .accept_en_i   (run && (word_cnt_q < WORDS_PER_POLY)),
        .word_valid_i  (sp_valid_i),
        .word_i        (sp_data_i),
        .hold_i        (samp_hold_i),
        .word_rdy_o    (sp_rdy_o),
        .chunk_valid_o (samp_valid_o),
        .chunk_o       (samp_data_o),
        .chunk_take_o  (chunk_take)
    );

    // A coefficient is only taken against a chunk that has actually left the buffer.
    assign coef_take = coef_valid_i & run & ~poly_done & ((pend_q != '0) | chunk_take);

    always_ff @(posedge clk) begin
        if (clr) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_i) state_d = (num_poly_i == '0) ? ST_DONE : ST_REQ;
            ST_REQ:  state_d = ST_RUN;
            ST_RUN:  if (poly_done) state_d = (poly_left_q == NPOLY_W'(1)) ? ST_DONE : ST_REQ;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o   = (state_q != ST_IDLE);
        done_o   = (state_q == ST_DONE);
        sq_req_o = (state_q == ST_REQ);
        run      = (state_q == ST_RUN);
    end

    always_comb begin
        word_cnt_d  = word_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        pend_d      = pend_q;
        poly_left_d = poly_left_q;
        addr_d      = addr_q;
        if (state_q == ST_IDLE && start_i) begin
            addr_d      = base_addr_i;
            poly_left_d = num_poly_i;
        end
        if (state_q == ST_REQ) begin
            word_cnt_d = '0;
            wr_cnt_d   = '0;
        end
        if (word_take) word_cnt_d = word_cnt_q + 1'b1;
        if (coef_take) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
            addr_d   = addr_q + 1'b1;
        end
        if (chunk_take && !coef_take)      pend_d = pend_q + 1'b1;
        else if (!chunk_take && coef_take) pend_d = pend_q - 1'b1;
        if (run && poly_done) poly_left_d = poly_left_q - 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only; next-state values come from the combinational blocks.
    always_ff @(posedge clk) begin
        if (clr) begin
            word_cnt_q  <= '0;
            wr_cnt_q    <= '0;
            pend_q      <= '0;
            poly_left_q <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            word_cnt_q  <= word_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            pend_q      <= pend_d;
            poly_left_q <= poly_left_d;
            addr_q      <= addr_d;
            we_q        <= coef_take;
            if (coef_take) begin
                wr_addr_q <= addr_q;
                wr_data_q <= coef_i;
            end
        end
    end

    assign mem_we_o    = we_q;
    assign mem_addr_o  = wr_addr_q;
    assign mem_wdata_o = wr_data_q;

endmodule

// File: tb/tb_cbd_poly_sampler_seq.sv
// Self-checking bench: random sponge words and sampler stalls, with a reference model that
// derives every expected write (address and CBD coefficients) directly from the generated words.
module tb_cbd_poly_sampler_seq;
    import abr_params_pkg::*;

    localparam int WORD_W     = 64;
    localparam int MEM_ADDR_W = 15;
    localparam int NPOLY_W    = 3;
    localparam int Q          = 3329;
    localparam logic [COEF_W-1:0] OVR = {12'd3328, 12'd2, 12'd1, 12'd0};

    logic                  clk = 1'b0;
    logic                  rst, zeroize, start_i;
    logic [MEM_ADDR_W-1:0] base_addr_i;
    logic [NPOLY_W-1:0]    num_poly_i;
    logic                  busy_o, done_o, sq_req_o;
    logic                  sp_valid_i, sp_rdy_o;
    logic [WORD_W-1:0]     sp_data_i;
    logic                  samp_valid_o, samp_hold_i;
    logic [CHUNK_W-1:0]    samp_data_o;
    logic                  coef_valid_i;
    logic [COEF_W-1:0]     coef_i;
    logic                  mem_we_o;
    logic [MEM_ADDR_W-1:0] mem_addr_o;
    logic [COEF_W-1:0]     mem_wdata_o;

    always #5 clk = ~clk;

    cbd_poly_sampler_seq #(
        .WORD_W     (WORD_W),
        .MEM_ADDR_W (MEM_ADDR_W),
        .NPOLY_W    (NPOLY_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .zeroize      (zeroize),
        .start_i      (start_i),
        .base_addr_i  (base_addr_i),
        .num_poly_i   (num_poly_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .sq_req_o     (sq_req_o),
        .sp_valid_i   (sp_valid_i),
        .sp_data_i    (sp_data_i),
        .sp_rdy_o     (sp_rdy_o),
        .samp_valid_o (samp_valid_o),
        .samp_data_o  (samp_data_o),
        .samp_hold_i  (samp_hold_i),
        .coef_valid_i (coef_valid_i),
        .coef_i       (coef_i),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o)
    );

    typedef struct {
        logic [MEM_ADDR_W-1:0] addr;
        logic [COEF_W-1:0]     data;
    } wr_t;

    wr_t               exp_q[$];
    logic [WORD_W-1:0] src_q[$];
    wr_t               mon_e;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic                  cont_valid, use_pattern, ovr_pending;
    int                    hold_mode;
    logic [MEM_ADDR_W-1:0] run_base;
    int                    exp_idx;
    int                    sq_cnt, done_cnt, word_cnt, wr_cnt, chunk_cnt;
    int                    first_we_cyc, last_we_cyc, done_cyc, start_cyc;
    logic [CHUNK_W-1:0]    first_chunk, burst_data;
    logic [COEF_W-1:0]     first_wdata;
    int                    burst_left, hold_bad;
    logic                  burst_done, hold, in_burst;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // CBD eta=2: each 4-bit group gives (b0+b1)-(b2+b3) mod q, lowest group in the lowest lane
    function automatic logic [COEF_W-1:0] cbd_ref(input logic [CHUNK_W-1:0] chunk);
        logic [COEF_W-1:0] r;
        int a, b, v;
        r = '0;
        for (int k = 0; k < COEFF_PER_CLK; k++) begin
            a = int'(chunk[4*k]) + int'(chunk[4*k+1]);
            b = int'(chunk[4*k+2]) + int'(chunk[4*k+3]);
            v = a - b;
            if (v < 0) v += Q;
            r[12*k +: 12] = v[11:0];
        end
        return r;
    endfunction

    function automatic logic [127:0] out_vec();
        return {busy_o, done_o, sq_req_o, sp_rdy_o, samp_valid_o, samp_data_o,
                mem_we_o, mem_addr_o, mem_wdata_o};
    endfunction

    // One squeeze: 16 fresh words plus a surplus word that must stay unaccepted.
    task automatic gen_poly();
        logic [WORD_W-1:0] w;
        logic              first;
        wr_t               e;
        first = (exp_idx == 0);
        src_q.delete();
        for (int i = 0; i < 16; i++) begin
            w = {$urandom, $urandom};
            if (use_pattern && first && i == 0) w = 64'h0000_0000_0000_A521;
            src_q.push_back(w);
            for (int c = 0; c < 4; c++) begin
                e.addr = MEM_ADDR_W'((int'(run_base) + exp_idx) % (1 << MEM_ADDR_W));
                e.data = cbd_ref(CHUNK_W'(w >> (16 * c)));
                if (use_pattern && exp_idx == 0) e.data = OVR;
                exp_q.push_back(e);
                exp_idx++;
            end
        end
        src_q.push_back({$urandom, $urandom});
    endtask

    // Sponge, sampler and write monitor, all acting at the falling edge.
    initial begin
        sp_valid_i   = 1'b0;
        sp_data_i    = '0;
        samp_hold_i  = 1'b0;
        coef_valid_i = 1'b0;
        coef_i       = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (sq_req_o === 1'b1) begin
                gen_poly();
                sq_cnt++;
            end
            if (done_o === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (mem_we_o === 1'b1) begin
                if (wr_cnt == 0) begin
                    first_we_cyc = cyc;
                    first_wdata  = mem_wdata_o;
                end
                last_we_cyc = cyc;
                wr_cnt++;
                if (exp_q.size() == 0) check("wr_extra", 1, 0);
                else begin
                    mon_e = exp_q.pop_front();
                    check("wr_addr", mem_addr_o, mon_e.addr);
                    check("wr_data", mem_wdata_o, mon_e.data);
                end
            end
            hold     = 1'b0;
            in_burst = 1'b0;
            if (hold_mode == 1) hold = ($urandom_range(3) == 0);
            else if (hold_mode == 2) begin
                if (burst_left > 0) begin
                    hold = 1'b1;
                    in_burst = 1'b1;
                    burst_left--;
                    if (samp_data_o !== burst_data) hold_bad++;
                end else if (!burst_done && chunk_cnt == 10 && samp_valid_o === 1'b1) begin
                    hold = 1'b1;
                    in_burst = 1'b1;
                    burst_left = 4;
                    burst_done = 1'b1;
                    burst_data = samp_data_o;
                end
            end
            samp_hold_i  = hold;
            coef_valid_i = (samp_valid_o === 1'b1) && !hold;
            if (coef_valid_i) begin
                if (chunk_cnt == 0) first_chunk = samp_data_o;
                if (ovr_pending) begin
                    coef_i = OVR;
                    ovr_pending = 1'b0;
                end else coef_i = cbd_ref(samp_data_o);
                chunk_cnt++;
            end else coef_i = '0;
            if (src_q.size() > 0 && (cont_valid || $urandom_range(3) != 0)) begin
                sp_valid_i = 1'b1;
                sp_data_i  = src_q[0];
            end else sp_valid_i = 1'b0;
            #1;
            if (in_burst && sp_rdy_o !== 1'b0) hold_bad++;
            if (sp_valid_i && sp_rdy_o === 1'b1) begin
                void'(src_q.pop_front());
                word_cnt++;
            end
        end
    end

    always @(posedge clk)
        if (!rst && !zeroize)
            assert (!coef_valid_i || samp_valid_o) else $error("coef_valid_i without samp_valid_o");

    task automatic clr_run(input logic [MEM_ADDR_W-1:0] base, input logic cont,
                           input int hmode, input logic pat);
        run_base = base; exp_idx = 0; cont_valid = cont; hold_mode = hmode;
        use_pattern = pat; ovr_pending = pat;
        sq_cnt = 0; done_cnt = 0; word_cnt = 0; wr_cnt = 0; chunk_cnt = 0;
        burst_left = 0; burst_done = 1'b0; hold_bad = 0;
        exp_q.delete();
        src_q.delete();
    endtask

    task automatic pulse_start(input logic [MEM_ADDR_W-1:0] base, input logic [NPOLY_W-1:0] n);
        @(negedge clk); #2;
        start_i = 1'b1; base_addr_i = base; num_poly_i = n; start_cyc = cyc;
        @(negedge clk); #2;
        start_i = 1'b0; base_addr_i = MEM_ADDR_W'($urandom); num_poly_i = NPOLY_W'($urandom);
    endtask

    task automatic run_cmd(input string name, input logic [MEM_ADDR_W-1:0] base,
                           input int n, input logic cont, input int hmode,
                           input logic pat, input logic poke);
        logic ok;
        clr_run(base, cont, hmode, pat);
        pulse_start(base, NPOLY_W'(n));
        if (poke) begin
            repeat (40) @(negedge clk);
            #2;
            check({name, "_busy"}, busy_o, 1);
            pulse_start(15'h0123, 3'd5);
        end
        ok = 1'b0;
        for (int i = 0; i < 300 * n + 50 && !ok; i++) begin
            @(negedge clk); #2;
            if (done_cnt > 0) ok = 1'b1;
        end
        check({name, "_done_seen"}, ok, 1);
        repeat (3) @(negedge clk);
        #2;
        check({name, "_done_cnt"}, done_cnt, 1);
        check({name, "_sq_cnt"}, sq_cnt, n);
        check({name, "_words"}, word_cnt, 16 * n);
        check({name, "_writes"}, wr_cnt, 64 * n);
        check({name, "_exp_left"}, exp_q.size(), 0);
        check({name, "_idle"}, busy_o, 0);
    endtask

    initial begin
        logic ok;
        rst = 1'b1; zeroize = 1'b0; start_i = 1'b0;
        base_addr_i = '0; num_poly_i = '0;
        clr_run('0, 1'b1, 0, 1'b0);
        repeat (3) @(negedge clk);
        #2;
        check("rst_outputs", out_vec(), '0);
        rst = 1'b0;

        run_cmd("single", 15'h100, 1, 1'b1, 0, 1'b0, 1'b0);
        check("single_first_addr_gap", first_we_cyc - start_cyc, 4);
        check("single_write_span", last_we_cyc - first_we_cyc, 63);
        check("single_done_lat", done_cyc - last_we_cyc, 1);

        run_cmd("pattern", 15'h100, 1, 1'b1, 0, 1'b1, 1'b0);
        check("pattern_chunk0", first_chunk, 16'hA521);
        check("pattern_wdata0", first_wdata, OVR);

        run_cmd("hold", 15'h300, 1, 1'b1, 2, 1'b0, 1'b0);
        check("hold_burst_done", burst_done, 1);
        check("hold_stable", hold_bad, 0);

        run_cmd("multi", 15'h7FF0, 3, 1'b0, 1, 1'b0, 1'b1);

        clr_run(15'h055, 1'b1, 0, 1'b0);
        pulse_start(15'h055, 3'd0);
        repeat (4) @(negedge clk);
        #2;
        check("zero_done_cnt", done_cnt, 1);
        check("zero_done_lat", done_cyc - start_cyc, 1);
        check("zero_sq_cnt", sq_cnt, 0);
        check("zero_writes", wr_cnt, 0);

        clr_run(15'h200, 1'b1, 0, 1'b0);
        pulse_start(15'h200, 3'd1);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); #2;
            if (wr_cnt >= 20) begin
                ok = 1'b1;
                break;
            end
        end
        check("zeroize_reach20", ok, 1);
        zeroize = 1'b1;
        @(posedge clk); #1;
        check("zeroize_outputs", out_vec(), '0);
        zeroize = 1'b0;
        repeat (20) @(negedge clk);
        #2;
        check("zeroize_no_done", done_cnt, 0);
        check("zeroize_wr_stop", wr_cnt, 20);

        run_cmd("after_zeroize", 15'h100, 1, 1'b1, 0, 1'b0, 1'b0);
        check("after_zeroize_span", last_we_cyc - first_we_cyc, 63);
        check("after_zeroize_done_lat", done_cyc - last_we_cyc, 1);

        for (int r = 0; r < 3; r++)
            run_cmd("random", MEM_ADDR_W'($urandom), int'($urandom_range(3, 1)), 1'b0, 1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
